ciphertext_framer: RTL and testbench
====================================

# ciphertext_framer

Downstream consumer of the ciphertext serializer. Captures one serial ciphertext frame (bit stream plus data-valid flag), checks its length, and replays it as a byte stream over a valid/ready handshake. It can optionally append an XOR checksum byte. It also pulses error/overrun indications and counts completed frames for the debug path.

## Interface
Parameters:
- MSG_SIZE, 64, frame length in bits; must be a multiple of 8 and ≥ 8.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  global enable; low freezes all state, outputs hold.
- iData_in  in  1  serial ciphertext bit (from serializer oData_out).
- iData_flag  in  1  high while iData_in carries a valid bit (from serializer oData_flag).
- oByte  out  8  current output byte.
- oByte_valid  out  1  oByte valid.
- iByte_ready  in  1  consumer accepts oByte when valid && ready.
- oLast  out  1  high with oByte_valid on the final byte of a frame.
- oFrame_error  out  1  one-cycle pulse: flag dropped before MSG_SIZE bits.
- oOverrun  out  1  one-cycle pulse: new frame started while draining.
- oBusy  out  1  high in any state other than IDLE.
- oFrame_count  out  8  completed frames, wraps 255 → 0.

## Operation
- Reset: state IDLE; shift register, bit counter, byte index, prev-flag register, oByte, oByte_valid, oLast, pulses, oFrame_count all 0.
- Bit counter width $clog2(MSG_SIZE)+1. Bit order is MSB-first: first received bit lands in shift register bit MSG_SIZE-1.
- All transitions below require ena=1. With ena=0 nothing changes, including prev-flag.
- IDLE:
  - iData_flag=1 → shift in bit, count=1, go SHIFT.
  - If MSG_SIZE==8 and that bit completes the frame, apply the SHIFT completion rule.
- SHIFT:
  - iData_flag=1 → shift in bit, count+1.
  - If count reaches MSG_SIZE → go DRAIN, byte index 0.
  - iData_flag=0 with count<MSG_SIZE → oFrame_error pulse, discard data, go IDLE.
- DRAIN:
  - oByte_valid=1 and oByte = byte[index], where byte 0 is bits MSG_SIZE-1..MSG_SIZE-8.
  - On valid&&ready: index+1.
  - After byte MSG_SIZE/8-1 is accepted → CKSUM if enabled, else IDLE with oFrame_count+1.
  - iData_flag bits arriving during DRAIN/CKSUM are discarded.
  - A flag rising edge (flag=1, prev-flag=0) in DRAIN/CKSUM → oOverrun pulse. The flag remaining high after a full frame is not an overrun.
  - Leaving DRAIN/CKSUM with the flag still high does not start a new frame; a fresh rising edge is required in IDLE.
- oLast: high on the last byte presented (checksum byte if enabled, else data byte MSG_SIZE/8-1).
- oByte/oByte_valid must stay stable while valid && !ready.
- Reset mid-frame or mid-drain aborts silently: no error pulse, oFrame_count cleared.

## Timing
- Last frame bit sampled at cycle N → oByte_valid=1 at cycle N+1.
- One byte accepted per cycle at most; with ready tied high, a 64-bit frame drains in 8 cycles (9 with checksum).
- oByte_valid falls the cycle after the last byte is accepted; oFrame_count updates in that same cycle.
- oFrame_error/oOverrun: registered, high exactly one cycle, the cycle after the offending sample.
- Earliest next-frame capture: first cycle back in IDLE.

## Configuration
- CIPHER_FRAMER_CHECKSUM_EN defined:
  - After the last data byte, state CKSUM presents oByte = XOR of all MSG_SIZE/8 data bytes, with oLast=1.
  - Frame completes when that byte is accepted.
- Undefined:
  - No CKSUM state; the frame completes on acceptance of the last data byte.
  - Checksum logic absent.

## Test plan
- Frame 0xDEADBEEF00000001, ready=1, macro off → bytes DE AD BE EF 00 00 00 01; oLast on 01; first valid 1 cycle after last bit; oFrame_count=1.
- Same frame, macro on → ninth byte 0x23 with oLast=1; oFrame_count=1.
- Flag drops after 37 bits → oFrame_error high one cycle, no oByte_valid, oFrame_count unchanged, then a valid frame captures normally.
- Frame 0x0123456789ABCDEF, ready toggling 1,0,0,1,…, with ena=0 for 3 cycles mid-drain → oByte held stable while stalled; byte order 01..EF intact.
- New flag rising edge during drain → oOverrun pulse; drained bytes unchanged; the new bits are not captured.
- rst asserted after 20 bits, then a full frame 0xFFFFFFFFFFFFFFFF → no error pulse; output FF×8; oFrame_count=1.

Source files
------------

// File: rtl/ciphertext_framer.sv
// Captures one serial ciphertext frame and replays it MSB-first as bytes over valid/ready.
// Define CIPHER_FRAMER_CHECKSUM_EN to append an XOR checksum byte after the data bytes.
module ciphertext_framer #(
    parameter int unsigned MSG_SIZE = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       iData_in,
    input  logic       iData_flag,
    output logic [7:0] oByte,
    output logic       oByte_valid,
    input  logic       iByte_ready,
    output logic       oLast,
    output logic       oFrame_error,
    output logic       oOverrun,
    output logic       oBusy,
    output logic [7:0] oFrame_count
);

    localparam int unsigned NB = MSG_SIZE / 8;
    localparam int unsigned CW = $clog2(MSG_SIZE) + 1;
    localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;
`ifdef CIPHER_FRAMER_CHECKSUM_EN
    localparam bit CksumEn = 1'b1;
`else
    localparam bit CksumEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StShift, StDrain, StCksum} state_e;

    state_e                state;
    logic [MSG_SIZE-1:0]   shreg;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic                  flag_q;

    logic [MSG_SIZE-1:0]   sh_next;
    logic [CW-1:0]         cnt_next;
    logic [IW-1:0]         idx_inc;
    logic                  accept;
    logic                  rise;
    logic                  last_data;

    // Byte 0 is the most significant byte of the frame.
    function automatic logic [7:0] byte_at(input logic [MSG_SIZE-1:0] v, input int unsigned i);
        logic [MSG_SIZE-1:0] t;
        t = v << (8 * i);
        return t[MSG_SIZE-1 -: 8];
    endfunction

    assign sh_next   = {shreg[MSG_SIZE-2:0], iData_in};
    assign cnt_next  = cnt + CW'(1);
    assign idx_inc   = idx + IW'(1);
    assign accept    = oByte_valid && iByte_ready;
    assign rise      = iData_flag && !flag_q;
    assign last_data = (idx == IW'(NB - 1));
    assign oBusy     = (state != StIdle);

`ifdef CIPHER_FRAMER_CHECKSUM_EN
    logic [7:0] cksum;
    always_comb begin
        cksum = '0;
        for (int i = 0; i < int'(NB); i++) begin
            cksum = cksum ^ shreg[8*i +: 8];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            shreg        <= '0;
            cnt          <= '0;
            idx          <= '0;
            flag_q       <= 1'b0;
            oByte        <= '0;
            oByte_valid  <= 1'b0;
            oLast        <= 1'b0;
            oFrame_error <= 1'b0;
            oOverrun     <= 1'b0;
            oFrame_count <= '0;
        end else begin
            // Pulses are events: they never outlast one cycle, even if ena drops.
            oFrame_error <= 1'b0;
            oOverrun     <= 1'b0;
            if (ena) begin
                flag_q <= iData_flag;
                unique case (state)
                    StIdle, StShift: begin
                        // In IDLE a new frame needs a fresh rising edge of the flag.
                        if (iData_flag && (state == StShift || !flag_q)) begin
                            shreg <= sh_next;
                            if (cnt_next == CW'(MSG_SIZE)) begin
                                cnt         <= '0;
                                idx         <= '0;
                                state       <= StDrain;
                                oByte       <= byte_at(sh_next, 0);
                                oByte_valid <= 1'b1;
                                oLast       <= !CksumEn && (NB == 1);
                            end else begin
                                cnt   <= cnt_next;
                                state <= StShift;
                            end
                        end else if (state == StShift) begin
                            oFrame_error <= 1'b1;
                            shreg        <= '0;
                            cnt          <= '0;
                            state        <= StIdle;
                        end
                    end
                    StDrain: begin
                        if (rise) oOverrun <= 1'b1;
                        if (accept) begin
                            if (last_data) begin
`ifdef CIPHER_FRAMER_CHECKSUM_EN
                                state <= StCksum;
                                oByte <= cksum;
                                oLast <= 1'b1;
`else
                                state        <= StIdle;
                                idx          <= '0;
                                oByte_valid  <= 1'b0;
                                oLast        <= 1'b0;
                                oFrame_count <= oFrame_count + 8'd1;
`endif
                            end else begin
                                idx   <= idx_inc;
                                oByte <= byte_at(shreg, int'(idx_inc));
                                oLast <= !CksumEn && (idx_inc == IW'(NB - 1));
                            end
                        end
                    end
`ifdef CIPHER_FRAMER_CHECKSUM_EN
                    StCksum: begin
                        if (rise) oOverrun <= 1'b1;
                        if (accept) begin
                            state        <= StIdle;
                            idx          <= '0;
                            oByte_valid  <= 1'b0;
                            oLast        <= 1'b0;
                            oFrame_count <= oFrame_count + 8'd1;
                        end
                    end
`endif
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ciphertext_framer.sv
// Self-checking bench for ciphertext_framer: table vectors, random frames and corner sequences.
module tb_ciphertext_framer;

    localparam int unsigned MSG = 64;
    localparam int NB = MSG / 8;
`ifdef CIPHER_FRAMER_CHECKSUM_EN
    localparam int NOUT = NB + 1;
`else
    localparam int NOUT = NB;
`endif

    logic       clk = 1'b0;
    logic       rst, ena, iData_in, iData_flag, iByte_ready;
    logic [7:0] oByte, oFrame_count;
    logic       oByte_valid, oLast, oFrame_error, oOverrun, oBusy;

    ciphertext_framer #(.MSG_SIZE(MSG)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .iData_in     (iData_in),
        .iData_flag   (iData_flag),
        .oByte        (oByte),
        .oByte_valid  (oByte_valid),
        .iByte_ready  (iByte_ready),
        .oLast        (oLast),
        .oFrame_error (oFrame_error),
        .oOverrun     (oOverrun),
        .oBusy        (oBusy),
        .oFrame_count (oFrame_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int n_err = 0;
    int n_ovr = 0;
    int exp_count = 0;
    logic [7:0] got_b[$];
    logic       got_l[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: byte k of a frame, most significant first, and the XOR of all data bytes.
    function automatic logic [7:0] mbyte(input logic [63:0] f, input int k);
        return 8'(f >> (8 * (NB - 1 - k)));
    endfunction

    function automatic logic [7:0] mck(input logic [63:0] f);
        logic [7:0] x = 8'h00;
        for (int k = 0; k < NB; k++) x = x ^ mbyte(f, k);
        return x;
    endfunction

    // Negedge monitor: records accepted bytes, counts pulses, checks stall stability.
    logic       pend = 1'b0;
    logic [7:0] pb;
    logic       pl;
    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                check("stall_valid", 64'(oByte_valid), 64'd1);
                check("stall_byte", 64'(oByte), 64'(pb));
                check("stall_last", 64'(oLast), 64'(pl));
            end
            pend = oByte_valid && !(iByte_ready && ena);
            pb = oByte;
            pl = oLast;
            if (ena && oByte_valid && iByte_ready) begin
                got_b.push_back(oByte);
                got_l.push_back(oLast);
            end
            if (oFrame_error) n_err++;
            if (oOverrun) n_ovr++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [63:0] f, input int n);
        got_b.delete();
        got_l.delete();
        for (int i = 0; i < n; i++) begin
            iData_flag = 1'b1;
            iData_in = f[63-i];
            if (i == int'(MSG) - 1) check("early_valid", 64'(oByte_valid), 64'd0);
            step();
        end
        if (n == int'(MSG)) check("first_valid", 64'(oByte_valid), 64'd1);
    endtask

    // rnd=1: random ready; otherwise pat[c%8]. ena is low for 3 cycles from stall_at.
    task automatic drain(input logic [7:0] pat, input bit rnd, input int stall_at);
        bit done = 1'b0;
        for (int c = 0; c < 300; c++) begin
            ena = !(stall_at >= 0 && c >= stall_at && c < stall_at + 3);
            iByte_ready = rnd ? ($urandom_range(0, 3) != 0) : pat[c%8];
            step();
            if (!oBusy) begin
                done = 1'b1;
                break;
            end
        end
        ena = 1'b1;
        iByte_ready = 1'b0;
        check("drain_timeout", 64'(done), 64'd1);
        check("valid_after", 64'(oByte_valid), 64'd0);
    endtask

    task automatic verify(input logic [63:0] f, input logic [7:0] ck);
        logic [7:0] e;
        exp_count++;
        check("nbytes", 64'(got_b.size()), 64'(NOUT));
        for (int k = 0; k < got_b.size() && k < NOUT; k++) begin
            e = (k < NB) ? mbyte(f, k) : ck;
            check($sformatf("byte%0d", k), 64'(got_b[k]), 64'(e));
            check($sformatf("last%0d", k), 64'(got_l[k]), 64'(k == NOUT - 1));
        end
        check("count", 64'(oFrame_count), 64'(exp_count[7:0]));
    endtask

    typedef struct {
        logic [63:0] frame;
        logic [7:0]  pat;
        int          stall_at;
        logic [7:0]  cksum;
    } vec_t;

    vec_t vt[3];
    int   e0, o0;
    logic [63:0] rf;

    initial begin
        vt[0] = '{64'hDEADBEEF00000001, 8'hFF, -1, 8'h23};
        vt[1] = '{64'h0123456789ABCDEF, 8'b1001_1001, 4, 8'h00};
        vt[2] = '{64'hFFFFFFFFFFFFFFFF, 8'hFF, -1, 8'h00};

        rst = 1'b1; ena = 1'b1; iData_in = 1'b0; iData_flag = 1'b0; iByte_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        check("rst_valid", 64'(oByte_valid), 64'd0);
        check("rst_byte", 64'(oByte), 64'd0);
        check("rst_last", 64'(oLast), 64'd0);
        check("rst_busy", 64'(oBusy), 64'd0);
        check("rst_count", 64'(oFrame_count), 64'd0);
        check("rst_err", 64'(oFrame_error), 64'd0);

        // Table vectors.
        for (int v = 0; v < 3; v++) begin
            e0 = n_err; o0 = n_ovr;
            send_bits(vt[v].frame, MSG);
            iData_flag = 1'b0;
            drain(vt[v].pat, 1'b0, vt[v].stall_at);
            verify(vt[v].frame, vt[v].cksum);
            check("tbl_err", 64'(n_err - e0), 64'd0);
            check("tbl_ovr", 64'(n_ovr - o0), 64'd0);
            step();
        end

        // Short frame: flag drops after 37 bits.
        e0 = n_err;
        send_bits(64'hA5A5A5A5A5A5A5A5, 37);
        iData_flag = 1'b0;
        step();
        check("err_pulse", 64'(oFrame_error), 64'd1);
        check("err_novalid", 64'(oByte_valid), 64'd0);
        step();
        check("err_width", 64'(oFrame_error), 64'd0);
        check("err_busy", 64'(oBusy), 64'd0);
        check("err_count", 64'(oFrame_count), 64'(exp_count[7:0]));
        check("err_n", 64'(n_err - e0), 64'd1);
        send_bits(64'hC0FFEE0012345678, MSG);
        iData_flag = 1'b0;
        drain(8'hFF, 1'b0, -1);
        verify(64'hC0FFEE0012345678, mck(64'hC0FFEE0012345678));

        // Overrun: new rising edge while draining.
        o0 = n_ovr; e0 = n_err;
        send_bits(64'h0011223344556677, MSG);
        iData_flag = 1'b0;
        iByte_ready = 1'b0;
        step();
        iData_flag = 1'b1;
        for (int i = 0; i < 5; i++) begin
            iData_in = i[0];
            step();
            if (i == 0) check("ovr_pulse", 64'(oOverrun), 64'd1);
            if (i == 1) check("ovr_width", 64'(oOverrun), 64'd0);
        end
        iData_flag = 1'b0;
        drain(8'hFF, 1'b0, -1);
        verify(64'h0011223344556677, mck(64'h0011223344556677));
        check("ovr_n", 64'(n_ovr - o0), 64'd1);
        step(); step();
        check("ovr_nocapture", 64'(oBusy), 64'd0);
        check("ovr_err", 64'(n_err - e0), 64'd0);

        // Flag held high after a full frame: no overrun, no restart.
        o0 = n_ovr;
        send_bits(64'h8000000000000001, MSG);
        drain(8'hFF, 1'b0, -1);
        verify(64'h8000000000000001, mck(64'h8000000000000001));
        step(); step(); step();
        check("hold_busy", 64'(oBusy), 64'd0);
        check("hold_ovr", 64'(n_ovr - o0), 64'd0);
        iData_flag = 1'b0;
        step();

        // Reset mid-frame aborts silently.
        e0 = n_err;
        send_bits(64'h123456789ABCDEF0, 20);
        iData_flag = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_count = 0;
        step();
        check("rstmid_busy", 64'(oBusy), 64'd0);
        check("rstmid_count", 64'(oFrame_count), 64'd0);
        check("rstmid_err", 64'(n_err - e0), 64'd0);
        send_bits(64'hFFFFFFFFFFFFFFFF, MSG);
        iData_flag = 1'b0;
        drain(8'hFF, 1'b0, -1);
        verify(64'hFFFFFFFFFFFFFFFF, 8'h00);

        // Random frames with random back-pressure.
        for (int r = 0; r < 20; r++) begin
            rf = {$urandom, $urandom};
            e0 = n_err; o0 = n_ovr;
            send_bits(rf, MSG);
            iData_flag = 1'b0;
            drain(8'h00, 1'b1, (r % 4 == 0) ? 2 : -1);
            verify(rf, mck(rf));
            check("rnd_pulses", 64'((n_err - e0) + (n_ovr - o0)), 64'd0);
            if (r % 2 == 0) step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
